// File: rtl/axil_reg_file_if.sv
// AXI-Lite bus bundle for axil_reg_file: AW/W/B/AR/R channels with master and slave views.
interface axil_reg_file_if #(
  parameter int ADDR_W = 12
) ();
  logic              awValid;
  logic              awReady;
  logic [ADDR_W-1:0] awAddr;
  logic [2:0]        awProt;
  logic              wValid;
  logic              wReady;
  logic [31:0]       wData;
  logic [3:0]        wStrb;
  logic              bValid;
  logic              bReady;
  logic [1:0]        bResp;
  logic              arValid;
  logic              arReady;
  logic [ADDR_W-1:0] arAddr;
  logic [2:0]        arProt;
  logic              rValid;
  logic              rReady;
  logic [31:0]       rData;
  logic [1:0]        rResp;

  modport master (
    output awValid, awAddr, awProt, wValid, wData, wStrb, bReady,
           arValid, arAddr, arProt, rReady,
    input  awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
  );

  modport slave (
    input  awValid, awAddr, awProt, wValid, wData, wStrb, bReady,
           arValid, arAddr, arProt, rReady,
    output awReady, wReady, bValid, bResp, arReady, rValid, rData, rResp
  );
endinterface

// File: rtl/axil_reg_file.sv
// AXI-Lite register bank: NUM_REGS x 32-bit registers, independent read/write FSMs, DECERR on misses.
// Optional byte strobes enabled by defining AXIL_REG_FILE_STRB_EN.
module axil_reg_file #(
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  axil_reg_file_if.slave           bus,
  output logic [NUM_REGS*32-1:0]   regsOut,
  output logic [NUM_REGS-1:0]      wrPulse
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}            rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [NUM_REGS-1:0][31:0] regs;
  logic [IDX_W-1:0]          aw_idx_q;
  logic [31:0]               w_data_q;
  logic [3:0]                w_strb_q;

  logic             aw_hs, w_hs, ar_hs;
  logic             commit, c_hit, ar_hit;
  logic [IDX_W-1:0] c_idx, ar_idx;
  logic [31:0]      c_data, rd_data;
  logic [3:0]       c_strb;

  function automatic logic is_hit(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
  endfunction

`ifdef AXIL_REG_FILE_STRB_EN
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] din,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = din[8*b +: 8];
    return res;
  endfunction
  logic unused_ok;
  assign unused_ok = ^{bus.awProt, bus.arProt, bus.awAddr[1:0], bus.arAddr[1:0]};
`else
  logic unused_ok;
  assign unused_ok = ^{bus.awProt, bus.arProt, bus.awAddr[1:0], bus.arAddr[1:0], c_strb};
`endif

  assign aw_hs  = bus.awValid & bus.awReady;
  assign w_hs   = bus.wValid  & bus.wReady;
  assign ar_hs  = bus.arValid & bus.arReady;
  assign ar_idx = bus.arAddr[ADDR_W-1:2];
  assign ar_hit = is_hit(ar_idx);
  assign c_hit  = is_hit(c_idx);

  // Commit mixes live and held channel values depending on which half arrived first.
  always_comb begin
    commit = 1'b0;
    c_idx  = aw_idx_q;
    c_data = w_data_q;
    c_strb = w_strb_q;
    case (wstate)
      W_IDLE: if (aw_hs && w_hs) begin
        commit = 1'b1;
        c_idx  = bus.awAddr[ADDR_W-1:2];
        c_data = bus.wData;
        c_strb = bus.wStrb;
      end
      W_AW: if (w_hs) begin
        commit = 1'b1;
        c_data = bus.wData;
        c_strb = bus.wStrb;
      end
      W_W: if (aw_hs) begin
        commit = 1'b1;
        c_idx  = bus.awAddr[ADDR_W-1:2];
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (ar_hit && ar_idx == IDX_W'(i)) rd_data = regs[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wstate      <= W_IDLE;
      bus.awReady <= 1'b0;
      bus.wReady  <= 1'b0;
      bus.bValid  <= 1'b0;
      bus.bResp   <= '0;
      aw_idx_q    <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
    end else if (commit) begin
      wstate      <= W_RESP;
      bus.awReady <= 1'b0;
      bus.wReady  <= 1'b0;
      bus.bValid  <= 1'b1;
      bus.bResp   <= c_hit ? OKAY : DECERR;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            wstate      <= W_AW;
            aw_idx_q    <= bus.awAddr[ADDR_W-1:2];
            bus.awReady <= 1'b0;
            bus.wReady  <= 1'b1;
          end else if (w_hs) begin
            wstate      <= W_W;
            w_data_q    <= bus.wData;
            w_strb_q    <= bus.wStrb;
            bus.awReady <= 1'b1;
            bus.wReady  <= 1'b0;
          end else begin
            bus.awReady <= 1'b1;
            bus.wReady  <= 1'b1;
          end
        end
        W_RESP: if (bus.bReady) begin
          wstate      <= W_IDLE;
          bus.bValid  <= 1'b0;
          bus.awReady <= 1'b1;
          bus.wReady  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      regs    <= '0;
      wrPulse <= '0;
    end else begin
      wrPulse <= '0;
      if (commit && c_hit) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (c_idx == IDX_W'(i)) begin
`ifdef AXIL_REG_FILE_STRB_EN
            regs[i] <= strb_merge(regs[i], c_data, c_strb);
`else
            regs[i] <= c_data;
`endif
            wrPulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rstate      <= R_IDLE;
      bus.arReady <= 1'b0;
      bus.rValid  <= 1'b0;
      bus.rData   <= '0;
      bus.rResp   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate      <= R_DATA;
            bus.arReady <= 1'b0;
            bus.rValid  <= 1'b1;
            bus.rData   <= rd_data;
            bus.rResp   <= ar_hit ? OKAY : DECERR;
          end else begin
            bus.arReady <= 1'b1;
          end
        end
        R_DATA: if (bus.rReady) begin
          rstate      <= R_IDLE;
          bus.rValid  <= 1'b0;
          bus.arReady <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign regsOut = regs;

endmodule

// File: tb/tb_axil_reg_file.sv
// Directed bench for axil_reg_file: vector table of single transactions plus hand-written
// sequences for skewed channels, backpressure, read/write collision and mid-transaction reset.
module tb_axil_reg_file;
  localparam int ADDR_W   = 12;
  localparam int NUM_REGS = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  axil_reg_file_if #(.ADDR_W(ADDR_W)) bus ();
  logic [NUM_REGS*32-1:0] regsOut;
  logic [NUM_REGS-1:0]    wrPulse;

  axil_reg_file #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .regsOut(regsOut),
    .wrPulse(wrPulse)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_regs [NUM_REGS];

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm);
    logic [NUM_REGS*32-1:0] e;
    for (int i = 0; i < NUM_REGS; i++) e[32*i +: 32] = exp_regs[i];
    checks++;
    if (regsOut !== e) begin
      errors++;
      $display("FAIL %s regsOut: got %h, expected %h", nm, regsOut, e);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regsOut[32*i +: 32];
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 32'h0;
  endtask

  task automatic wr(input string nm, input logic [11:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] er);
    logic [15:0] ep;
    logic [9:0]  idx;
    idx = a[11:2];
    ep  = (idx < 10'd16) ? (16'd1 << idx[3:0]) : 16'd0;
    bus.awValid = 1'b1; bus.awAddr = a; bus.awProt = 3'b101;
    bus.wValid  = 1'b1; bus.wData  = d; bus.wStrb  = s;
    bus.bReady  = 1'b1;
    for (int k = 0; k < 20 && !(bus.awReady && bus.wReady); k++) tick();
    chk({nm, " aw/w ready"}, 32'(bus.awReady & bus.wReady), 32'd1);
    tick();
    bus.awValid = 1'b0; bus.wValid = 1'b0;
    chk({nm, " bValid"}, 32'(bus.bValid), 32'd1);
    chk({nm, " bResp"}, 32'(bus.bResp), 32'(er));
    chk({nm, " wrPulse"}, 32'(wrPulse), 32'(ep));
    tick();
    chk({nm, " bValid drop"}, 32'(bus.bValid), 32'd0);
    chk({nm, " wrPulse drop"}, 32'(wrPulse), 32'd0);
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] ed,
                    input logic [1:0] er);
    bus.arValid = 1'b1; bus.arAddr = a; bus.arProt = 3'b011; bus.rReady = 1'b1;
    for (int k = 0; k < 20 && !bus.arReady; k++) tick();
    chk({nm, " arReady"}, 32'(bus.arReady), 32'd1);
    tick();
    bus.arValid = 1'b0;
    chk({nm, " rValid"}, 32'(bus.rValid), 32'd1);
    chk({nm, " rData"}, bus.rData, ed);
    chk({nm, " rResp"}, 32'(bus.rResp), 32'(er));
    tick();
    chk({nm, " rValid drop"}, 32'(bus.rValid), 32'd0);
  endtask

  task automatic chk_idle_reset(input string nm);
    chk({nm, " awReady"}, 32'(bus.awReady), 32'd0);
    chk({nm, " wReady"},  32'(bus.wReady),  32'd0);
    chk({nm, " arReady"}, 32'(bus.arReady), 32'd0);
    chk({nm, " bValid"},  32'(bus.bValid),  32'd0);
    chk({nm, " rValid"},  32'(bus.rValid),  32'd0);
    chk({nm, " wrPulse"}, 32'(wrPulse),     32'd0);
    clear_exp();
    chk_regs(nm);
  endtask

  task automatic chk_readies(input string nm);
    chk({nm, " awReady"}, 32'(bus.awReady), 32'd1);
    chk({nm, " wReady"},  32'(bus.wReady),  32'd1);
    chk({nm, " arReady"}, 32'(bus.arReady), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    bus.awValid = 1'b0; bus.awAddr = '0; bus.awProt = '0;
    bus.wValid  = 1'b0; bus.wData  = '0; bus.wStrb  = '0;
    bus.bReady  = 1'b0;
    bus.arValid = 1'b0; bus.arAddr = '0; bus.arProt = '0;
    bus.rReady  = 1'b0;
    clear_exp();

    vecs[0]  = '{1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 12'h008, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h040, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0};
    vecs[3]  = '{1'b0, 12'h040, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[4]  = '{1'b1, 12'h004, 32'hAABBCCDD, 4'hF, 2'b00, 32'hAABBCCDD};
`ifdef AXIL_REG_FILE_STRB_EN
    vecs[5]  = '{1'b1, 12'h004, 32'h11223344, 4'h5, 2'b00, 32'hAA22CC44};
    vecs[6]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hAA22CC44};
`else
    vecs[5]  = '{1'b1, 12'h004, 32'h11223344, 4'h5, 2'b00, 32'h11223344};
    vecs[6]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'h11223344};
`endif
    vecs[7]  = '{1'b1, 12'h03F, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, 12'h03C, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 12'hFFC, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[10] = '{1'b1, 12'h001, 32'h00000001, 4'h3, 2'b00, 32'h00000001};
    vecs[11] = '{1'b0, 12'h002, 32'h0,        4'h0, 2'b00, 32'h00000001};

    // Reset state and ready rise
    tick(); tick();
    chk_idle_reset("reset");
    chk("reset bResp", 32'(bus.bResp), 32'd0);
    chk("reset rResp", 32'(bus.rResp), 32'd0);
    chk("reset rData", bus.rData, 32'd0);
    rstn = 1'b1;
    tick();
    chk_readies("post-reset");

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].wr) begin
        wr($sformatf("vec%0d", v), vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].resp);
        if (vecs[v].resp == 2'b00) exp_regs[vecs[v].addr[5:2]] = vecs[v].exp;
        chk_regs($sformatf("vec%0d", v));
      end else begin
        rd($sformatf("vec%0d", v), vecs[v].addr, vecs[v].exp, vecs[v].resp);
      end
    end

`ifdef AXIL_REG_FILE_STRB_EN
    wr("strb0", 12'h004, 32'hFFFFFFFF, 4'h0, 2'b00);
    chk_regs("strb0");
`endif

    // W leads AW by three cycles
    bus.wValid = 1'b1; bus.wData = 32'h12345678; bus.wStrb = 4'hF; bus.bReady = 1'b1;
    for (int k = 0; k < 20 && !bus.wReady; k++) tick();
    tick();
    bus.wValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("skewW wReady c%0d", k), 32'(bus.wReady), 32'd0);
      chk($sformatf("skewW bValid c%0d", k), 32'(bus.bValid), 32'd0);
      if (k < 2) tick();
    end
    bus.awValid = 1'b1; bus.awAddr = 12'h00C;
    tick();
    bus.awValid = 1'b0;
    chk("skewW bValid", 32'(bus.bValid), 32'd1);
    chk("skewW wrPulse", 32'(wrPulse), 32'h0008);
    chk("skewW reg3", reg_at(3), 32'h12345678);
    exp_regs[3] = 32'h12345678;
    tick();

    // AW leads W
    bus.awValid = 1'b1; bus.awAddr = 12'h010;
    tick();
    bus.awValid = 1'b0;
    chk("skewAW awReady", 32'(bus.awReady), 32'd0);
    chk("skewAW wReady", 32'(bus.wReady), 32'd1);
    tick();
    chk("skewAW bValid idle", 32'(bus.bValid), 32'd0);
    bus.wValid = 1'b1; bus.wData = 32'h0BADF00D; bus.wStrb = 4'hF;
    tick();
    bus.wValid = 1'b0;
    chk("skewAW bValid", 32'(bus.bValid), 32'd1);
    chk("skewAW wrPulse", 32'(wrPulse), 32'h0010);
    exp_regs[4] = 32'h0BADF00D;
    tick();
    chk_regs("skew");
    rd("skew rd3", 12'h00C, 32'h12345678, 2'b00);
    rd("skew rd4", 12'h010, 32'h0BADF00D, 2'b00);

    // Read response stalled five cycles while a new AR waits
    bus.arValid = 1'b1; bus.arAddr = 12'h00C; bus.rReady = 1'b0;
    tick();
    bus.arAddr = 12'h010;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rstall rValid c%0d", k), 32'(bus.rValid), 32'd1);
      chk($sformatf("rstall rData c%0d", k), bus.rData, 32'h12345678);
      chk($sformatf("rstall arReady c%0d", k), 32'(bus.arReady), 32'd0);
      tick();
    end
    bus.arValid = 1'b0; bus.rReady = 1'b1;
    tick();
    chk("rstall release", 32'(bus.rValid), 32'd0);

    // Write response stalled
    bus.bReady = 1'b0;
    bus.awValid = 1'b1; bus.awAddr = 12'h01C; bus.wValid = 1'b1; bus.wData = 32'h77; bus.wStrb = 4'hF;
    tick();
    bus.awValid = 1'b0; bus.wValid = 1'b0;
    exp_regs[7] = 32'h77;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bstall bValid c%0d", k), 32'(bus.bValid), 32'd1);
      chk($sformatf("bstall awReady c%0d", k), 32'(bus.awReady), 32'd0);
    end
    bus.bReady = 1'b1;
    tick();
    chk("bstall release", 32'(bus.bValid), 32'd0);
    chk_regs("bstall");

    // Same-cycle read and write of reg 2
    wr("coll pre", 12'h008, 32'h1, 4'hF, 2'b00);
    bus.arValid = 1'b1; bus.arAddr = 12'h008; bus.rReady = 1'b0;
    bus.awValid = 1'b1; bus.awAddr = 12'h008; bus.wValid = 1'b1; bus.wData = 32'h2; bus.wStrb = 4'hF;
    tick();
    bus.arValid = 1'b0; bus.awValid = 1'b0; bus.wValid = 1'b0;
    chk("coll rData", bus.rData, 32'h1);
    chk("coll bValid", 32'(bus.bValid), 32'd1);
    chk("coll reg2", reg_at(2), 32'h2);
    bus.rReady = 1'b1;
    tick();

    // Reset while holding an address in W_AW
    bus.awValid = 1'b1; bus.awAddr = 12'h014;
    tick();
    bus.awValid = 1'b0;
    chk("rstAW awReady", 32'(bus.awReady), 32'd0);
    rstn = 1'b0;
    tick();
    chk_idle_reset("rstAW");
    rstn = 1'b1;
    tick();
    chk_readies("rstAW after");
    bus.wValid = 1'b1; bus.wData = 32'h55; bus.wStrb = 4'hF;
    tick();
    bus.wValid = 1'b0;
    chk("rstAW no stale commit", 32'(bus.bValid), 32'd0);
    chk("rstAW no pulse", 32'(wrPulse), 32'd0);
    bus.awValid = 1'b1; bus.awAddr = 12'h018;
    tick();
    bus.awValid = 1'b0;
    chk("rstAW wrPulse", 32'(wrPulse), 32'h0040);
    exp_regs[6] = 32'h55;
    chk_regs("rstAW");
    tick();

    // Reset with B and R responses pending
    bus.bReady = 1'b0; bus.rReady = 1'b0;
    bus.awValid = 1'b1; bus.awAddr = 12'h018; bus.wValid = 1'b1; bus.wData = 32'h66;
    bus.arValid = 1'b1; bus.arAddr = 12'h018;
    tick();
    bus.awValid = 1'b0; bus.wValid = 1'b0; bus.arValid = 1'b0;
    chk("rstB bValid pending", 32'(bus.bValid), 32'd1);
    chk("rstB rValid pending", 32'(bus.rValid), 32'd1);
    rstn = 1'b0;
    tick();
    chk_idle_reset("rstB");
    chk("rstB rData", bus.rData, 32'd0);
    rstn = 1'b1; bus.bReady = 1'b1; bus.rReady = 1'b1;
    tick();
    chk_readies("rstB after");
    chk("rstB bValid after", 32'(bus.bValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
